// File: rtl/ddr3_pkg.sv
// Shared encodings for the DDR3 command responder: command codes, error causes
// and the {CS,RAS,CAS,WE} pin patterns.
package ddr3_pkg;

  localparam logic [3:0] CMD_NOP  = 4'd0;
  localparam logic [3:0] CMD_ACT  = 4'd1;
  localparam logic [3:0] CMD_RD   = 4'd2;
  localparam logic [3:0] CMD_WR   = 4'd3;
  localparam logic [3:0] CMD_PRE  = 4'd4;
  localparam logic [3:0] CMD_PREA = 4'd5;
  localparam logic [3:0] CMD_REF  = 4'd6;
  localparam logic [3:0] CMD_MRS  = 4'd7;
  localparam logic [3:0] CMD_ZQCL = 4'd8;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
  localparam logic [2:0] ERR_CLOSED   = 3'd2;
  localparam logic [2:0] ERR_BUSY     = 3'd3;
  localparam logic [2:0] ERR_REF_OPEN = 3'd4;
  localparam logic [2:0] ERR_STROBE   = 3'd5;

  // {CS, RAS, CAS, WE}, all active low
  localparam logic [3:0] PAT_ACT  = 4'b0011;
  localparam logic [3:0] PAT_RD   = 4'b0101;
  localparam logic [3:0] PAT_WR   = 4'b0100;
  localparam logic [3:0] PAT_PRE  = 4'b0010;
  localparam logic [3:0] PAT_REF  = 4'b0001;
  localparam logic [3:0] PAT_MRS  = 4'b0000;
  localparam logic [3:0] PAT_ZQCL = 4'b0110;

endpackage

// File: rtl/ddr3_bank_tracker.sv
// Per-bank IDLE/OPEN state and open row for 8 banks; handles ACT, PRE, PREA
// and auto-precharge. Callers only assert enables for already-legal commands.
module ddr3_bank_tracker (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        act_en,
  input  logic        pre_en,
  input  logic        prea_en,
  input  logic        ap_en,
  input  logic [2:0]  ba,
  input  logic [14:0] row,
  output logic [7:0]  bank_open,
  output logic [14:0] open_row
);

  logic [7:0]  open_q, open_d;
  logic [14:0] row_q [8];
  logic [14:0] row_d [8];

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    open_d = open_q;
    row_d  = row_q;
    if (act_en) begin
      open_d[ba] = 1'b1;
      row_d[ba]  = row;
    end
    if (pre_en || ap_en) open_d[ba] = 1'b0;
    if (prea_en)         open_d     = '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (RESET) begin
      open_q <= '0;
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  assign bank_open = open_q;
  assign open_row  = row_q[ba];

endmodule

// File: rtl/ddr3_cmd_responder.sv
// Memory-side DDR3 responder: command decode and legality checks, refresh timer,
// CWL write / CL read pipelines and a small byte-maskable backing array.
module ddr3_cmd_responder
  import ddr3_pkg::*;
#(
  parameter int CL        = 5,
  parameter int CWL       = 4,
  parameter int TRFC      = 8,
  parameter int COL_IDX_W = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CKE,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [2:0]  BA,
  input  logic [14:0] Addr,
  input  logic [15:0] DQ_in,
  input  logic        LDQS,
  input  logic        UDQS,
  input  logic        LDM,
  input  logic        UDM,
  output logic [15:0] DQ_rd,
  output logic        DQ_rd_valid,
  output logic [3:0]  cmd_code,
  output logic [7:0]  bank_open,
  output logic        busy,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int IDX_W  = 3 + COL_IDX_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int BUSY_W = $clog2(TRFC + 1);

  logic [3:0]        cmd;
  logic [IDX_W-1:0]  cmd_idx;
  logic              act_en, pre_en, prea_en, ap_en, rd_acc, wr_acc, ref_acc;
  logic [2:0]        cmd_err;
  logic [14:0]       open_row;

  logic [3:0]        cmd_code_q, cmd_code_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              err_q, err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [CWL-1:0]    wr_vld_q, wr_vld_d;
  logic [IDX_W-1:0]  wr_idx_q [CWL];
  logic [IDX_W-1:0]  wr_idx_d [CWL];
  logic [CL-1:0]     rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]  rd_idx_q [CL];
  logic [IDX_W-1:0]  rd_idx_d [CL];
  logic [15:0]       dq_rd_q, dq_rd_d;
  logic              dq_rd_valid_q;
  logic [15:0]       mem_q [DEPTH];

  logic              wr_commit, lo_we, hi_we, strobe_err;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign cmd_idx = {BA, Addr[COL_IDX_W-1:0]};

  always_comb begin
    cmd = CMD_NOP;
    if (CKE) begin
      unique case ({CS, RAS, CAS, WE})
        PAT_ACT:  cmd = CMD_ACT;
        PAT_RD:   cmd = CMD_RD;
        PAT_WR:   cmd = CMD_WR;
        PAT_PRE:  cmd = Addr[10] ? CMD_PREA : CMD_PRE;
        PAT_REF:  cmd = CMD_REF;
        PAT_MRS:  cmd = CMD_MRS;
        PAT_ZQCL: cmd = Addr[10] ? CMD_ZQCL : CMD_NOP;
        default:  cmd = CMD_NOP;
      endcase
    end
  end

  // Busy wins over every other check; a rejected command has no side effects.
  always_comb begin
    act_en  = 1'b0;
    pre_en  = 1'b0;
    prea_en = 1'b0;
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    ref_acc = 1'b0;
    cmd_err = ERR_NONE;
    if (cmd != CMD_NOP) begin
      if (busy_cnt_q != '0) begin
        cmd_err = ERR_BUSY;
      end else begin
        unique case (cmd)
          CMD_ACT:  if (bank_open[BA]) cmd_err = ERR_ACT_OPEN; else act_en = 1'b1;
          CMD_RD:   if (!bank_open[BA]) cmd_err = ERR_CLOSED; else rd_acc = 1'b1;
          CMD_WR:   if (!bank_open[BA]) cmd_err = ERR_CLOSED; else wr_acc = 1'b1;
          CMD_PRE:  pre_en  = 1'b1;
          CMD_PREA: prea_en = 1'b1;
          CMD_REF:  if (|bank_open) cmd_err = ERR_REF_OPEN; else ref_acc = 1'b1;
          default:  if (|bank_open) cmd_err = ERR_REF_OPEN;
        endcase
      end
    end
  end

  assign ap_en = (rd_acc || wr_acc) && Addr[10];

  ddr3_bank_tracker u_banks (
    .CLK       (CLK),
    .RESET     (RESET),
    .act_en    (act_en),
    .pre_en    (pre_en),
    .prea_en   (prea_en),
    .ap_en     (ap_en),
    .ba        (BA),
    .row       (Addr),
    .bank_open (bank_open),
    .open_row  (open_row)
  );

  // The open row is tracked for debug visibility only; nothing here consumes it.
  logic unused_open_row;
  assign unused_open_row = ^open_row;

  assign wr_commit  = wr_vld_q[CWL-1];
  assign wr_idx     = wr_idx_q[CWL-1];
  assign rd_idx     = rd_idx_q[CL-1];
  assign lo_we      = wr_commit && !LDM && LDQS;
  assign hi_we      = wr_commit && !UDM && UDQS;
  assign strobe_err = wr_commit && ((!LDM && !LDQS) || (!UDM && !UDQS));

  always_comb begin
    cmd_code_d = cmd;
    err_d      = (cmd_err != ERR_NONE) || strobe_err;
    err_code_d = err_code_q;
    if (cmd_err != ERR_NONE) err_code_d = cmd_err;
    else if (strobe_err)     err_code_d = ERR_STROBE;

    busy_cnt_d = busy_cnt_q;
    if (ref_acc)                busy_cnt_d = BUSY_W'(TRFC);
    else if (busy_cnt_q != '0)  busy_cnt_d = busy_cnt_q - BUSY_W'(1);

    wr_vld_d[0] = wr_acc;
    wr_idx_d[0] = cmd_idx;
    for (int i = 1; i < CWL; i++) begin
      wr_vld_d[i] = wr_vld_q[i-1];
      wr_idx_d[i] = wr_idx_q[i-1];
    end
    rd_vld_d[0] = rd_acc;
    rd_idx_d[0] = cmd_idx;
    for (int i = 1; i < CL; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_idx_d[i] = rd_idx_q[i-1];
    end

    // A write committing to the fetched word this edge is forwarded byte by byte.
    dq_rd_d = '0;
    if (rd_vld_q[CL-1]) begin
      dq_rd_d = mem_q[rd_idx];
      if (wr_idx == rd_idx) begin
        if (lo_we) dq_rd_d[7:0]  = DQ_in[7:0];
        if (hi_we) dq_rd_d[15:8] = DQ_in[15:8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cmd_code_q    <= CMD_NOP;
      busy_cnt_q    <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      wr_vld_q      <= '0;
      rd_vld_q      <= '0;
      dq_rd_q       <= '0;
      dq_rd_valid_q <= 1'b0;
      for (int i = 0; i < CWL; i++) wr_idx_q[i] <= '0;
      for (int i = 0; i < CL; i++)  rd_idx_q[i] <= '0;
    end else begin
      cmd_code_q    <= cmd_code_d;
      busy_cnt_q    <= busy_cnt_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      wr_vld_q      <= wr_vld_d;
      wr_idx_q      <= wr_idx_d;
      rd_vld_q      <= rd_vld_d;
      rd_idx_q      <= rd_idx_d;
      dq_rd_q       <= dq_rd_d;
      dq_rd_valid_q <= rd_vld_q[CL-1];
    end
  end

  // NOTE: the storage array has no reset; clearing it would need a per-word reset network and its contents are undefined until written anyway.
  always_ff @(posedge CLK) begin
    if (lo_we) mem_q[wr_idx][7:0]  <= DQ_in[7:0];
    if (hi_we) mem_q[wr_idx][15:8] <= DQ_in[15:8];
  end

  assign DQ_rd       = dq_rd_q;
  assign DQ_rd_valid = dq_rd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign busy        = busy_cnt_q != '0;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed self-checking bench for ddr3_cmd_responder with default parameters
// (CL=5, CWL=4, TRFC=8, COL_IDX_W=3); expected values are hand-computed.
module tb_ddr3_cmd_responder;

  localparam int T_CL   = 5;
  localparam int T_CWL  = 4;
  localparam int T_TRFC = 8;

  // {CS,RAS,CAS,WE}
  localparam logic [3:0] P_NOP = 4'b1111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;

  logic        CLK = 1'b0;
  logic        RESET, CKE, CS, RAS, CAS, WE;
  logic [2:0]  BA;
  logic [14:0] Addr;
  logic [15:0] DQ_in;
  logic        LDQS, UDQS, LDM, UDM;
  logic [15:0] DQ_rd;
  logic        DQ_rd_valid;
  logic [3:0]  cmd_code;
  logic [7:0]  bank_open;
  logic        busy, err;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  ddr3_cmd_responder dut (
    .CLK(CLK), .RESET(RESET), .CKE(CKE), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .BA(BA), .Addr(Addr), .DQ_in(DQ_in), .LDQS(LDQS), .UDQS(UDQS), .LDM(LDM), .UDM(UDM),
    .DQ_rd(DQ_rd), .DQ_rd_valid(DQ_rd_valid), .cmd_code(cmd_code), .bank_open(bank_open),
    .busy(busy), .err(err), .err_code(err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] pat, input logic [2:0] ba, input logic [14:0] addr);
    @(negedge CLK);
    {CS, RAS, CAS, WE} = pat;
    BA   = ba;
    Addr = addr;
    @(posedge CLK);
    #1;
    {CS, RAS, CAS, WE} = P_NOP;
  endtask

  // dqs = {UDQS,LDQS}, dm = {UDM,LDM}; returns just after the capture edge
  task automatic wr(input logic [2:0] ba, input logic [14:0] addr, input logic [15:0] data,
                    input logic [1:0] dqs, input logic [1:0] dm);
    issue(P_WR, ba, addr);
    step(T_CWL - 1);
    DQ_in = data;
    {UDQS, LDQS} = dqs;
    {UDM, LDM}   = dm;
    step(1);
    {UDQS, LDQS} = 2'b00;
    {UDM, LDM}   = 2'b11;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] ba, input logic [14:0] addr,
                          input logic [15:0] exp);
    issue(P_RD, ba, addr);
    step(T_CL - 1);
    check({tag, "_early"}, DQ_rd_valid, 1'b0);
    step(1);
    check({tag, "_valid"}, DQ_rd_valid, 1'b1);
    check({tag, "_data"}, DQ_rd, exp);
    step(1);
    check({tag, "_after"}, DQ_rd_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    RESET = 1'b1; CKE = 1'b1;
    {CS, RAS, CAS, WE} = P_NOP;
    BA = '0; Addr = '0; DQ_in = '0;
    {UDQS, LDQS} = 2'b00; {UDM, LDM} = 2'b11;
    step(3);
    @(negedge CLK) RESET = 1'b0;
    step(2);

    check("rst_valid", DQ_rd_valid, 1'b0);
    check("rst_dq", DQ_rd, 16'h0);
    check("rst_cmd", cmd_code, 4'd0);
    check("rst_banks", bank_open, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_errcode", err_code, 3'd0);

    // Basic write/read round trip on bank 3
    issue(P_ACT, 3'd3, 15'd5);
    check("act3_cmd", cmd_code, 4'd1);
    check("act3_open", bank_open, 8'h08);
    wr(3'd3, 15'd7, 16'hF00F, 2'b11, 2'b00);
    check("wr3_noerr", err, 1'b0);
    rd_check("rd3", 3'd3, 15'd7, 16'hF00F);

    // Upper byte masked: old upper byte survives
    issue(P_ACT, 3'd2, 15'h5D6E);
    check("act2_open", bank_open, 8'h0C);
    wr(3'd2, 15'h00F8, 16'h1234, 2'b11, 2'b00);
    wr(3'd2, 15'h00F8, 16'hA5A5, 2'b11, 2'b10);
    rd_check("rd2_mask", 3'd2, 15'h00F8, 16'h12A5);
    rd_check("rd2_ap", 3'd2, 15'h04F8, 16'h12A5);
    check("ap_closed", bank_open, 8'h08);

    // RD to closed bank: error, no data
    issue(P_RD, 3'd5, 15'd0);
    check("rdclosed_err", err, 1'b1);
    check("rdclosed_code", err_code, 3'd2);
    n = 0;
    for (int k = 1; k <= T_CL + 1; k++) begin
      step(1);
      if (k == 1) check("err_pulse", err, 1'b0);
      if (DQ_rd_valid) n++;
    end
    check("rdclosed_novalid", n, 0);
    check("errcode_held", err_code, 3'd2);

    issue(P_ACT, 3'd3, 15'd9);
    check("act_open_err", err, 1'b1);
    check("act_open_code", err_code, 3'd1);
    check("act_open_banks", bank_open, 8'h08);

    // PREA, REF, ACT during busy, busy length
    issue(P_PRE, 3'd0, 15'h0400);
    check("prea_banks", bank_open, 8'h00);
    issue(P_REF, 3'd0, 15'd0);
    check("ref_cmd", cmd_code, 4'd6);
    n = busy ? 1 : 0;
    for (int k = 1; k < 16; k++) begin
      if (k == 3) begin
        issue(P_ACT, 3'd1, 15'd0);
        check("busy_code", err_code, 3'd3);
        check("busy_banks", bank_open, 8'h00);
      end else begin
        step(1);
      end
      if (busy) n++;
    end
    check("busy_len", n, T_TRFC);

    issue(P_ACT, 3'd1, 15'd0);
    check("act1_open", bank_open, 8'h02);
    issue(P_REF, 3'd0, 15'd0);
    check("refopen_err", err, 1'b1);
    check("refopen_code", err_code, 3'd4);
    check("refopen_busy", busy, 1'b0);

    // Missing low strobe with DM=0: err 5, low byte kept
    wr(3'd1, 15'd3, 16'hBEEF, 2'b11, 2'b00);
    wr(3'd1, 15'd3, 16'h1111, 2'b10, 2'b00);
    check("strobe_err", err, 1'b1);
    check("strobe_code", err_code, 3'd5);
    rd_check("rd_strobe", 3'd1, 15'd3, 16'h11EF);

    // Read fetch and write commit to the same word on the same edge
    wr(3'd1, 15'd4, 16'h5555, 2'b11, 2'b00);
    issue(P_RD, 3'd1, 15'd4);
    issue(P_WR, 3'd1, 15'd4);
    step(T_CWL - 1);
    DQ_in = 16'hAAAA; {UDQS, LDQS} = 2'b11; {UDM, LDM} = 2'b01;
    step(1);
    {UDQS, LDQS} = 2'b00; {UDM, LDM} = 2'b11;
    check("bypass_valid", DQ_rd_valid, 1'b1);
    check("bypass_data", DQ_rd, 16'hAA55);
    rd_check("after_bypass", 3'd1, 15'd4, 16'hAA55);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) wr(3'd1, 15'(i), 16'hC000 + 16'(i), 2'b11, 2'b00);
    for (int i = 0; i < 4; i++) issue(P_RD, 3'd1, 15'(i));
    step(T_CL - 4);
    check("b2b_early", DQ_rd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("b2b_valid%0d", i), DQ_rd_valid, 1'b1);
      check($sformatf("b2b_data%0d", i), DQ_rd, 16'hC000 + 16'(i));
    end
    step(1);
    check("b2b_after", DQ_rd_valid, 1'b0);

    // Reset mid-burst
    for (int i = 0; i < 4; i++) issue(P_RD, 3'd1, 15'(i));
    step(T_CL - 3);
    check("burst_first", DQ_rd, 16'hC000);
    #2 RESET = 1'b1;
    #1;
    check("rst_mid_valid", DQ_rd_valid, 1'b0);
    check("rst_mid_dq", DQ_rd, 16'h0);
    check("rst_mid_banks", bank_open, 8'h00);
    @(negedge CLK) RESET = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (DQ_rd_valid) n++;
    end
    check("rst_mid_nodata", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_responder.md
Name: ddr3_cmd_responder

Overview:
- Memory-side end of the DDR3 command/data interface driven by the controller state machine.
- Decodes CS/RAS/CAS/WE/BA/Addr each cycle, tracks per-bank open rows and refresh busy time, and captures write data from DQ after CWL.
- Returns read data after CL from a small backing array, and flags protocol violations.
- Used as the synthesizable responder in controller benches and FPGA loopback.

Parameters:
- CL, 5, read latency in cycles (READ command to DQ_rd_valid), legal 2..11
- CWL, 4, write latency in cycles (WRITE command to DQ capture), legal 1..CL
- TRFC, 8, cycles the device is busy after REF
- COL_IDX_W, 3, column bits used to index the array; array depth = 8 << COL_IDX_W words of 16 bits

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-high reset
- CKE  in  1  clock enable; 0 = every command treated as NOP
- CS, RAS, CAS, WE  in  1 each  active-low command pins
- BA  in  3  bank address
- Addr  in  15  row on ACT; column on RD/WR (A10 = auto-precharge, A12 ignored)
- DQ_in  in  16  write data from controller
- LDQS, UDQS  in  1 each  write strobes per byte (must be 1 at capture)
- LDM, UDM  in  1 each  write mask per byte (1 = byte not written)
- DQ_rd  out  16  read data
- DQ_rd_valid  out  1  DQ_rd is valid this cycle
- cmd_code  out  4  registered decoded command: 0 NOP/DES, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS, 8 ZQCL
- bank_open  out  8  per-bank open flag
- busy  out  1  refresh in progress
- err  out  1  one-cycle pulse on protocol violation
- err_code  out  3  cause, held until next err: 1 ACT open bank, 2 RD/WR closed bank, 3 cmd during busy, 4 REF with bank open, 5 bad strobe

Behaviour:
- Reset: all outputs 0, all banks closed, pipelines emptied, busy counter 0. The array is not cleared; its contents are undefined until written.
- Decode (CS=0): ACT 0/0/1/1 (RAS/CAS/WE), RD 1/0/1, WR 1/0/0, PRE 0/1/0 with A10=0, PREA same with A10=1, REF 0/0/1, MRS 0/0/0, ZQCL 1/1/0 with A10=1. CS=1 or other codes = NOP.
- cmd_code is registered one cycle after the command edge.
- Bank FSM per bank, IDLE/OPEN:
  - ACT: IDLE->OPEN, store row.
  - PRE: OPEN->IDLE. PRE to an IDLE bank is legal and does nothing. PREA closes all banks.
  - RD/WR with A10=1: bank goes to IDLE at the same edge as the command.
- Global FSM READY/REFRESH:
  - REF in READY with all banks idle -> REFRESH, busy=1 for exactly TRFC cycles, then READY.
  - REF with any bank open -> err 4, no state change.
- Any non-NOP command while busy -> err 3 and the command is dropped.
- ACT to an OPEN bank -> err 1; the row is not changed.
- RD/WR to an IDLE bank -> err 2; the command is dropped (no pipeline entry).
- MRS and ZQCL: decoded only, no state change (legal only in READY with all banks idle, otherwise err 3/4 as above).
- Array index = {BA, Addr[COL_IDX_W-1:0]}. Row is not part of the index; aliasing across rows is intended.
- Write path:
  - Accepted WR pushes its index into a CWL-deep shift register.
  - At the edge CWL cycles after the command edge, DQ_in is sampled. A byte is written only if its DM=0 and its DQS=1.
  - DM=0 with DQS=0 on either byte -> err 5 and that byte is not written.
- Read path:
  - Accepted RD pushes its index into a CL-deep pipeline; the array is read in the final stage.
  - DQ_rd/DQ_rd_valid are asserted exactly CL cycles after the command edge, for one cycle per RD.
  - Back-to-back RDs every cycle are legal. DQ_rd = 0 when not valid.
- Write commit and read fetch to the same index in the same cycle: the read returns the newly written bytes (bypass); masked bytes return old data.
- CKE=0: commands are ignored, but the pipelines and the busy counter keep advancing.
- Simultaneous err causes in one cycle cannot occur except err 5 together with a command error; the priority is command error, then 5.
- Reset asserted mid-burst or mid-refresh: pending reads and writes are discarded immediately and busy drops asynchronously.

Decomposition:
- Shared package ddr3_pkg holds:
  - command code localparams,
  - err_code constants,
  - the {CS,RAS,CAS,WE} pattern constants.
- Sub-module ddr3_bank_tracker: 8-bank open/row state plus the PRE/PREA/auto-precharge logic, outputs bank_open.
- Decode, refresh timer, pipelines and array stay in the top module.

Test Plan:
- Reset then NOPs -> all outputs 0, bank_open=8'h00, busy=0.
- ACT BA=3 row 5; WR BA=3 col 7 with DQ_in=16'hF00F, DQS=2'b11, DM=0 at +4 cycles; RD BA=3 col 7 -> DQ_rd=16'hF00F with valid exactly 5 cycles after the RD edge.
- ACT BA=2 row 16'h5D6E; WR col 10'h7F8 with DQ=16'hA5A5, UDM=1; then RD -> DQ_rd upper byte equals prior contents, lower byte = 8'hA5; RD with A10=1 -> bank_open[2]=0.
- RD to closed BA=5 -> err=1 one cycle, err_code=2, no DQ_rd_valid; ACT BA=3 twice -> err_code=1.
- PREA then REF -> busy=1 for 8 cycles; ACT during busy -> err_code=3; REF with bank 1 open -> err_code=4.
- Four back-to-back RDs to cols 0..3 -> four consecutive valid cycles, in order. Assert RESET during the burst -> valid drops immediately and no further data appears.
